// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, frame geometry and parity helper.
// The RX side reuses the frame constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } tx_state_e;

  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = 8;

  // Even parity is the XOR of the data bits; odd parity inverts it.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] data,
                                       input logic                 odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Programmable bit-period counter: tick is high on the last cycle of each bit.
// clear restarts the period; the counter only advances while enable is high.
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_r;

  assign tick = enable && (cnt_r == div);

  // Bit-period counter, wraps to zero on each tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (enable) begin
      if (tick) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: pops the FWFT TX FIFO, supplies parity and
// strobes the 11-bit shift register at each bit boundary.
module uart_tx_ctrl #(
  parameter int DIV_W      = 16,
  parameter int FRAME_BITS = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_enable,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_rdata,
  output logic             fifo_rd_en,
  output logic             load_en,
  output logic             shift_en,
  output logic             parity_bit,
  output logic             tx_busy,
  output logic             tx_done
);

  import uart_pkg::*;

  localparam int              CNT_W    = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  tx_state_e        state_r;
  tx_state_e        state_s;
  logic [DIV_W-1:0] div_q_r;
  logic [CNT_W-1:0] bit_cnt_r;
  logic             tick_s;
  logic             baud_clear_s;
  logic             baud_en_s;
  logic             load_s;
  logic             shift_s;
  logic             done_s;

  assign baud_en_s    = (state_r == SEND);
  assign baud_clear_s = (state_r != SEND);

  uart_baud_gen #(
    .DIV_W (DIV_W)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .clear  (baud_clear_s),
    .enable (baud_en_s),
    .div    (div_q_r),
    .tick   (tick_s)
  );

  // Next-state and strobe decode; strobes come only from registered state/counters
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    shift_s = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (tx_enable && !fifo_empty) begin
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        load_s  = 1'b1;
        state_s = SEND;
      end
      SEND: begin
        if (tick_s) begin
          if (bit_cnt_r == LAST_BIT) begin
            // Stop bit done: chain straight into the next byte when allowed
            done_s = 1'b1;
            if (tx_enable && !fifo_empty) begin
              state_s = LOAD;
            end else begin
              state_s = IDLE;
            end
          end else begin
            shift_s = 1'b1;
            state_s = SEND;
          end
        end else begin
          state_s = SEND;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, latched divisor and bit counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      div_q_r   <= '0;
      bit_cnt_r <= '0;
    end else begin
      state_r <= state_s;
      if (state_r == LOAD) begin
        div_q_r   <= baud_div;
        bit_cnt_r <= '0;
      end else if (baud_en_s && tick_s) begin
        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
      end
    end
  end

  assign fifo_rd_en = load_s;
  assign load_en    = load_s;
  assign shift_en   = shift_s;
  assign tx_done    = done_s;
  assign tx_busy    = (state_r != IDLE);
  assign parity_bit = parity_en ? calc_parity(fifo_rdata, parity_odd) : 1'b1;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: FIFO and shift-register models around
// the DUT, with expected strobe timing derived from frame arithmetic.
module tb_uart_tx_ctrl;

  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             tx_enable;
  logic [DIV_W-1:0] baud_div;
  logic             parity_en;
  logic             parity_odd;
  logic             fifo_empty;
  logic [7:0]       fifo_rdata;
  logic             fifo_rd_en;
  logic             load_en;
  logic             shift_en;
  logic             parity_bit;
  logic             tx_busy;
  logic             tx_done;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]  mem [0:63];
  int          rd_ptr  = 0;
  int          wr_ptr  = 0;
  logic [10:0] line_sr = 11'h7FF;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_rdata = mem[rd_ptr % 64];

  uart_tx_ctrl #(
    .DIV_W      (DIV_W),
    .FRAME_BITS (11)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_enable  (tx_enable),
    .baud_div   (baud_div),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_rd_en (fifo_rd_en),
    .load_en    (load_en),
    .shift_en   (shift_en),
    .parity_bit (parity_bit),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  // FIFO pop and serial shift register driven by the DUT strobes
  always @(posedge clk) begin
    if (fifo_rd_en) rd_ptr <= rd_ptr + 1;
    if (load_en) line_sr <= {1'b1, parity_bit, fifo_rdata, 1'b0};
    else if (shift_en) line_sr <= {1'b1, line_sr[10:1]};
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic ref_parity(input logic [7:0] b, input logic pe, input logic po);
    if (!pe) return 1'b1;
    return ((($countones(b) % 2) == 1) ? 1'b1 : 1'b0) ^ po;
  endfunction

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 64] = b;
    wr_ptr++;
  endtask

  // Runs every queued byte with divisor d; baud_div is perturbed to alt mid-frame
  // and tx_enable is dropped after sample s_drop (0 = never).
  task automatic run_frames(input int d, input int alt, input int s_drop);
    int P, n_avail, n_exp, base, j, o, total;
    logic [10:0] fb;
    logic [7:0]  bj;
    logic        ld, sh, dn, bz;
    P       = 11 * (d + 1) + 1;
    n_avail = wr_ptr - rd_ptr;
    base    = rd_ptr;
    n_exp   = (n_avail > 0) ? 1 : 0;
    for (int k = 1; k < n_avail; k++) begin
      if (s_drop == 0 || k * P < s_drop) n_exp++;
      else break;
    end
    baud_div  = DIV_W'(d);
    tx_enable = 1'b1;
    total     = n_exp * P + 3;
    for (int s = 1; s <= total; s++) begin
      @(negedge clk);
      j  = (s - 1) / P;
      o  = (s - 1) % P;
      ld = 1'b0; sh = 1'b0; dn = 1'b0; bz = 1'b0;
      if (j < n_exp) begin
        bz = 1'b1;
        ld = (o == 0);
        sh = (o > 0) && (o % (d + 1) == 0) && (o / (d + 1) <= 10);
        dn = (o == 11 * (d + 1));
      end
      chk1("load_en", load_en, ld);
      chk1("fifo_rd_en", fifo_rd_en, ld);
      chk1("shift_en", shift_en, sh);
      chk1("tx_done", tx_done, dn);
      chk1("tx_busy", tx_busy, bz);
      if (j < n_exp && o > 0) begin
        bj = mem[(base + j) % 64];
        fb = {1'b1, ref_parity(bj, parity_en, parity_odd), bj, 1'b0};
        chk1("line", line_sr[0], fb[(o - 1) / (d + 1)]);
      end
      if (!fifo_empty) chk1("parity_bit", parity_bit, ref_parity(fifo_rdata, parity_en, parity_odd));
      if (s == 2) baud_div = DIV_W'(alt);
      if (s == P - 1) baud_div = DIV_W'(d);
      if (s_drop != 0 && s == s_drop) tx_enable = 1'b0;
    end
    chkn("pops", rd_ptr - base, n_exp);
    tx_enable = 1'b0;
    baud_div  = DIV_W'(d);
  endtask

  initial begin
    int n;
    int base;
    reset      = 1'b0;
    tx_enable  = 1'b0;
    baud_div   = '0;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    repeat (3) @(negedge clk);
    chk1("rst_fifo_rd_en", fifo_rd_en, 1'b0);
    chk1("rst_load_en", load_en, 1'b0);
    chk1("rst_shift_en", shift_en, 1'b0);
    chk1("rst_tx_busy", tx_busy, 1'b0);
    chk1("rst_tx_done", tx_done, 1'b0);
    reset = 1'b1;
    @(negedge clk);

    // Single byte 0xA5, even parity, 4 cycles per bit
    parity_en  = 1'b1;
    parity_odd = 1'b0;
    push(8'hA5);
    #1 chk1("parity_a5", parity_bit, 1'b0);
    run_frames(3, 3, 0);

    // Divisor changed 3 -> 7 mid-frame must not alter bit timing
    push(8'h3C);
    run_frames(3, 7, 0);

    // Back-to-back frames at one cycle per bit
    push(8'h55);
    push(8'h0F);
    run_frames(0, 0, 0);

    // Parity variants while held off by tx_enable=0
    parity_odd = 1'b1;
    push(8'h01);
    @(negedge clk);
    chk1("parity_odd_01", parity_bit, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("hold_rd_en", fifo_rd_en, 1'b0);
      chk1("hold_busy", tx_busy, 1'b0);
    end
    run_frames(1, 1, 0);
    push(8'h00);
    @(negedge clk);
    chk1("parity_odd_00", parity_bit, 1'b1);
    run_frames(0, 0, 0);
    parity_en = 1'b0;
    push(8'($urandom));
    @(negedge clk);
    chk1("parity_disabled", parity_bit, 1'b1);
    run_frames(2, 5, 0);

    // Enabled with an empty FIFO stays idle
    tx_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk1("empty_busy", tx_busy, 1'b0);
      chk1("empty_rd_en", fifo_rd_en, 1'b0);
    end
    tx_enable = 1'b0;

    // tx_enable dropped mid-frame: first frame completes, second waits
    parity_en  = 1'b1;
    parity_odd = 1'b0;
    push(8'hC3);
    push(8'h7E);
    run_frames(1, 1, 10);
    run_frames(1, 1, 0);

    // Randomised bursts
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) push(8'($urandom));
      parity_en  = 1'($urandom_range(0, 1));
      parity_odd = 1'($urandom_range(0, 1));
      run_frames($urandom_range(0, 3), $urandom_range(0, 15),
                 ($urandom_range(0, 1) == 1) ? $urandom_range(1, 60) : 0);
    end
    run_frames(1, 2, 0);

    // Reset pulsed mid-frame
    base = rd_ptr;
    push(8'h3C);
    baud_div  = DIV_W'(2);
    tx_enable = 1'b1;
    repeat (8) @(negedge clk);
    chk1("pre_reset_busy", tx_busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk1("mid_rst_fifo_rd_en", fifo_rd_en, 1'b0);
    chk1("mid_rst_load_en", load_en, 1'b0);
    chk1("mid_rst_shift_en", shift_en, 1'b0);
    chk1("mid_rst_tx_busy", tx_busy, 1'b0);
    chk1("mid_rst_tx_done", tx_done, 1'b0);
    tx_enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk1("post_rst_busy", tx_busy, 1'b0);
      chk1("post_rst_done", tx_done, 1'b0);
      chk1("post_rst_rd_en", fifo_rd_en, 1'b0);
    end
    chkn("post_rst_pops", rd_ptr, base + 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
